// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM states, default word width
// and the supported SPI mode.
package spi_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // {CPOL, CPHA}; only mode 0 is implemented.
    localparam logic [1:0] SPI_MODE = 2'd0;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with edge detection
// derived from the synchronised level and its previous value.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic areset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples SCLK/CS/MOSI on clk_i, assembles RX words
// and shifts a preloaded TX word out on MISO, MSB first, back-to-back per CS.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic lead_edge, trail_edge;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i    (clk_i),
        .areset_i (areset_i),
        .d_i      (sclk_i),
        .level_o  (sclk_level_unused),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    // CS idles high, so its chain resets to 1 to avoid a phantom select.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i    (clk_i),
        .areset_i (areset_i),
        .d_i      (cs_i),
        .level_o  (cs_level),
        .rise_o   (cs_rise),
        .fall_o   (cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i    (clk_i),
        .areset_i (areset_i),
        .d_i      (mosi_i),
        .level_o  (mosi_s),
        .rise_o   (mosi_rise_unused),
        .fall_o   (mosi_fall_unused)
    );

    assign lead_edge  = SPI_MODE[1] ? sclk_fall : sclk_rise;
    assign trail_edge = SPI_MODE[1] ? sclk_rise : sclk_fall;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                underrun_q, underrun_d;
    logic                udr_pend_q, udr_pend_d;
    logic                miso_q, miso_d;
    logic [DATA_W-1:0]   rx_word;
    logic                word_done;

    assign rx_word   = {rx_shift_q[DATA_W-2:0], mosi_s};
    assign word_done = lead_edge && (cnt_q == LAST_BIT);

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            udr_pend_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            udr_pend_q  <= udr_pend_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        udr_pend_d  = udr_pend_q;
        miso_d      = miso_q;

        // A consume only happens while full, a load only while empty: no bypass.
        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    udr_pend_d = 1'b0;
                    if (hold_full_q) begin
                        tx_shift_d  = hold_q;
                        hold_full_d = 1'b0;
                        miso_d      = hold_q[DATA_W-1];
                    end else begin
                        tx_shift_d = '0;
                        miso_d     = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    if (word_done) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                    end
                    state_d    = IDLE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                    udr_pend_d = 1'b0;
                    miso_d     = 1'b0;
                end else if (lead_edge) begin
                    rx_shift_d = rx_word;
                    // An empty reload only counts as underrun once the next word
                    // really starts; a CS release in between cancels it.
                    if (udr_pend_q) begin
                        underrun_d = 1'b1;
                        udr_pend_d = 1'b0;
                    end
                    if (word_done) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        if (hold_full_q) begin
                            tx_shift_d  = hold_q;
                            hold_full_d = 1'b0;
                        end else begin
                            tx_shift_d = '0;
                            udr_pend_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (trail_edge) begin
                    // Counter at 0 means a fresh word was just reloaded: present
                    // its MSB instead of shifting.
                    if (cnt_q == '0) begin
                        miso_d = tx_shift_q[DATA_W-1];
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        miso_d     = tx_shift_q[DATA_W-2];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign miso_o     = miso_q;
    assign tx_ready_o = ~hold_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = ~cs_level;
    assign underrun_o = underrun_q;

endmodule
